exec_muldiv_seq: RTL and testbench

Multi-cycle sequencer for multiply and divide operations in the execute stage of the 16-bit pipeline. The single-cycle ALU cannot perform these operations. The block accepts operands from the execute stage, runs an iterative shift-add multiply or a restoring divide over WIDTH cycles, and holds the pipeline stalled until a one-cycle done pulse presents the result. It has one requester and no arbitration. It sits beside the main ALU, and its result is muxed onto the ALU result path by the execute stage.

---
 rtl/exec_muldiv_seq_pkg.sv | 23 ++
 rtl/exec_muldiv_seq_step.sv | 49 ++++
 rtl/exec_muldiv_seq.sv | 117 +++++++++++
 tb/tb_exec_muldiv_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_muldiv_seq_pkg.sv
// Shared definitions for the execute-stage multi-cycle multiply/divide unit.
// Holds the operation encodings, the sequencer state encoding and the
// default datapath width used by the top level and its step datapath.
package exec_muldiv_seq_pkg;

  localparam int MULDIV_WIDTH = 16;

  // Bit 1 selects divide, bit 0 selects the upper half of the working
  // register as the result (MULHI high product, REMU remainder).
  typedef enum logic [1:0] {
    OP_MULLO = 2'b00,
    OP_MULHI = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/exec_muldiv_seq_step.sv
// Single-iteration datapath for the multi-cycle multiply/divide unit.
// The working register is split into an upper half (hi) and lower half (lo).
//   Multiply: {hi,lo} is the product register, lo starts as the multiplier,
//             operand is the multiplicand (add to hi on lo[0], shift right).
//   Divide:   hi is the partial remainder, lo starts as the dividend and
//             collects quotient bits, operand is the divisor.
// Ports:
//   is_div            : 1 selects a restoring-divide step, 0 a shift-add step
//   hi, lo            : current working register halves
//   operand           : multiplicand or divisor
//   hi_next, lo_next  : working register after one iteration
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    // Add keeps its carry so the right shift brings it into the product.
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    // Remainder shifted left with the next dividend bit, one extra bit so
    // the trial subtraction's sign is visible.
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    hi_next = hi;
    lo_next = lo;
    if (is_div) begin
      if (!diff[WIDTH]) begin
        hi_next = diff[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_next, lo_next} = {sum, lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/exec_muldiv_seq.sv
// Multi-cycle multiply/divide sequencer for the execute stage.
// Accepts one operation at a time, iterates WIDTH times through muldiv_step,
// stalls the pipeline while working and pulses done with the result.
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-low reset
//   start        : request an operation (taken in IDLE or DONE)
//   op           : 00 MULLO, 01 MULHI, 10 DIVU, 11 REMU (all unsigned)
//   opa, opb     : multiplicand/dividend and multiplier/divisor
//   flush        : abort the in-flight operation, blocks a same-cycle start
//   stall        : stall request to the pipeline
//   busy         : high while iterating
//   done         : one-cycle result-valid pulse
//   result       : operation result, held between pulses
//   div_by_zero  : with done, divide/remainder by a zero divisor
module exec_muldiv_seq
  import exec_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  op_e              op_q;
  logic [WIDTH-1:0] hi_q, lo_q, operand_q;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic [WIDTH-1:0] result_q;
  logic             dbz_q;

  logic             accept;
  logic             dbz_in;
  logic             last_iter;

  assign accept    = start && !flush && (state_q == ST_IDLE || state_q == ST_DONE);
  assign dbz_in    = op[1] && (opb == '0);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_q[1]),
    .hi      (hi_q),
    .lo      (lo_q),
    .operand (operand_q),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state. A divide by zero needs no iterations, so it goes straight
  // to DONE, also when it arrives back-to-back in the DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = dbz_in ? ST_DONE : ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (flush)          state_d = ST_IDLE;
        else if (last_iter) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch, iteration and result capture. Multiplies keep the
  // multiplier in lo; divides keep the dividend in lo. The result is picked
  // from the final iteration's output so it is ready in the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      op_q      <= OP_MULLO;
      hi_q      <= '0;
      lo_q      <= '0;
      operand_q <= '0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
    end else if (accept) begin
      cnt_q     <= '0;
      op_q      <= op_e'(op);
      hi_q      <= '0;
      lo_q      <= op[1] ? opa : opb;
      operand_q <= op[1] ? opb : opa;
      dbz_q     <= dbz_in;
      if (dbz_in) result_q <= op[0] ? opa : '1;
    end else if (state_q == ST_RUN && !flush) begin
      cnt_q <= cnt_q + 1'b1;
      hi_q  <= hi_next;
      lo_q  <= lo_next;
      if (last_iter) result_q <= op_q[0] ? hi_next : lo_next;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign stall       = accept || busy;
  assign result      = result_q;
  assign div_by_zero = done && dbz_q;

endmodule

// File: tb/tb_exec_muldiv_seq.sv
// Self-checking bench for exec_muldiv_seq. Stimulus pushes the hand-computed
// expected {result, div_by_zero} into a queue; a monitor pops and compares
// on every done pulse.
module tb_exec_muldiv_seq;
  import exec_muldiv_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        div_by_zero;

  int          checks;
  int          errors;
  logic [16:0] exp_q[$];

  exec_muldiv_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .opa         (opa),
    .opb         (opb),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("result", {16'd0, result}, {16'd0, e[16:1]});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[0]});
      end
    end
  end

  // Present a request for one cycle; stall must rise combinationally.
  // Operands are scrambled after acceptance since the DUT has latched them.
  task automatic start_op(input string name, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_res,
                          input logic exp_dbz, input bit push);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    if (push) exp_q.push_back({exp_res, exp_dbz});
    #1;
    check({name, "_stall_on_start"}, {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    opa   = 16'($urandom);
    opb   = 16'($urandom);
  endtask

  // Count cycles from acceptance to done, checking stall/busy while working.
  task automatic wait_done(input string name, input int exp_lat);
    int  lat;
    int  bad;
    bit  seen;
    lat  = 0;
    bad  = 0;
    seen = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        lat  = k;
        break;
      end
      if (!(stall && busy)) bad++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_stall_busy_run"}, bad, 0);
    if (seen) check({name, "_stall_in_done"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int done_cnt;
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 2'b00;
    opa    = '0;
    opb    = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_result", {16'd0, result}, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] MULLO 0x12 * 0x34");
    start_op("mullo_small", OP_MULLO, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1);
    wait_done("mullo_small", 17);
    @(posedge clk); #1;

    $display("[TB] MULHI/MULLO 0xFFFF * 0xFFFF");
    start_op("mulhi_max", OP_MULHI, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1);
    wait_done("mulhi_max", 17);
    @(posedge clk); #1;
    start_op("mullo_max", OP_MULLO, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1);
    wait_done("mullo_max", 17);
    @(posedge clk); #1;

    $display("[TB] DIVU then back-to-back REMU 100 / 7");
    start_op("divu", OP_DIVU, 16'd100, 16'd7, 16'h000E, 1'b0, 1);
    wait_done("divu", 17);
    start_op("remu_b2b", OP_REMU, 16'd100, 16'd7, 16'h0002, 1'b0, 1);
    check("remu_b2b_busy_no_gap", {31'd0, busy}, 32'd1);
    wait_done("remu_b2b", 17);
    @(posedge clk); #1;

    $display("[TB] divide by zero");
    start_op("divu_zero", OP_DIVU, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1);
    wait_done("divu_zero", 1);
    @(posedge clk); #1;
    start_op("remu_zero", OP_REMU, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1);
    wait_done("remu_zero", 1);
    @(posedge clk); #1;

    $display("[TB] start blocked by same-cycle flush");
    start = 1'b1;
    flush = 1'b1;
    op    = OP_MULLO;
    opa   = 16'd9;
    opb   = 16'd9;
    #1;
    check("flush_start_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);

    $display("[TB] flush on 5th RUN cycle");
    start_op("mullo_flushed", OP_MULLO, 16'd3, 16'd5, 16'h0000, 1'b0, 0);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_stall", {31'd0, stall}, 32'd0);
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("flush_no_done", done_cnt, 0);
    @(posedge clk); #1;
    start_op("mullo_after_flush", OP_MULLO, 16'd3, 16'd5, 16'h000F, 1'b0, 1);
    wait_done("mullo_after_flush", 17);
    @(posedge clk); #1;

    $display("[TB] asynchronous reset mid-RUN");
    start_op("mullo_reset", OP_MULLO, 16'h1234, 16'h0002, 16'h0000, 1'b0, 0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_stall", {31'd0, stall}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_result", {16'd0, result}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_op("mullo_after_reset", OP_MULLO, 16'd6, 16'd7, 16'h002A, 1'b0, 1);
    wait_done("mullo_after_reset", 17);
    @(posedge clk); #1;

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
